// File: rtl/fusion_unit_ctrl.sv
// Fusion unit sequencer: latches a job descriptor, issues lane-sized operand
// fetches, times accumulator enables through a fixed pipeline delay and hands
// the finished dot product off with valid/ready.
// Optional feature macro: FUSION_CTRL_PERF_EN adds the perf_cycles busy-cycle counter.
module fusion_unit_ctrl #(
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [3:0]       cfg_in_width,
  input  logic [3:0]       cfg_weight_width,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             cfg_err,
  output logic [3:0]       in_width_q,
  output logic [3:0]       weight_width_q,
  output logic             op_req_valid,
  input  logic             op_req_ready,
  output logic [LEN_W-1:0] op_req_idx,
  output logic [4:0]       op_req_lanes,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef FUSION_CTRL_PERF_EN
  output logic [31:0]      perf_cycles,
`endif
  output logic             busy
);

  localparam int unsigned CNT_W = LEN_W + 1;
  localparam logic [PIPE_DEPTH-1:0] ACC_BIT = PIPE_DEPTH'(1) << (PIPE_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state_q, state_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic [4:0]        lanes_q, lanes_nxt;
  logic [CNT_W-1:0]  issued_q, issued_nxt;
  logic [PIPE_DEPTH-1:0] dly_q, dly_nxt;
  logic [3:0]        in_width_nxt, weight_width_nxt;

  logic              cfg_ready_d, cfg_err_d, op_req_valid_d, acc_clr_d, out_valid_d, busy_d;
  logic [LEN_W-1:0]  op_req_idx_d;
  logic [4:0]        op_req_lanes_d;

  logic              cfg_legal_c, cfg_accept_c, cfg_reject_c;
  logic              req_fire_c, out_fire_c;
  logic [CNT_W-1:0]  issued_sum_c, remaining_c;
  logic [2:0]        shift_c;

  // One-hot test for a precision code.
  function automatic logic is_onehot(input logic [3:0] w);
    return (w != 4'd0) && ((w & (w - 4'd1)) == 4'd0);
  endfunction

  // log2 of bitbricks needed per operand: 1b/2b -> 1, 4b -> 2, 8b -> 4.
  function automatic logic [2:0] brick_log2(input logic [3:0] w);
    if (w[3])      return 3'd2;
    else if (w[2]) return 3'd1;
    else           return 3'd0;
  endfunction

  // Descriptor decode and handshake fires.
  always_comb begin
    cfg_legal_c  = is_onehot(cfg_in_width) && is_onehot(cfg_weight_width);
    cfg_accept_c = (state_q == ST_IDLE) && cfg_valid && cfg_legal_c;
    cfg_reject_c = (state_q == ST_IDLE) && cfg_valid && !cfg_legal_c;
    req_fire_c   = op_req_valid && op_req_ready;
    out_fire_c   = out_valid && out_ready;
    issued_sum_c = issued_q + CNT_W'(op_req_lanes);
    shift_c      = brick_log2(cfg_in_width) + brick_log2(cfg_weight_width);
  end

  // Next-state, job registers and registered-output next values.
  always_comb begin
    state_nxt        = state_q;
    len_nxt          = len_q;
    lanes_nxt        = lanes_q;
    issued_nxt       = issued_q;
    in_width_nxt     = in_width_q;
    weight_width_nxt = weight_width_q;
    dly_nxt          = (dly_q << 1) | PIPE_DEPTH'(req_fire_c);
    remaining_c      = '0;
    cfg_ready_d      = 1'b0;
    cfg_err_d        = cfg_reject_c;
    op_req_valid_d   = 1'b0;
    op_req_idx_d     = '0;
    op_req_lanes_d   = '0;
    acc_clr_d        = 1'b0;
    out_valid_d      = 1'b0;
    busy_d           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_accept_c) begin
          state_nxt        = ST_CLR;
          len_nxt          = cfg_len;
          lanes_nxt        = 5'(5'd16 >> shift_c);
          issued_nxt       = '0;
          in_width_nxt     = cfg_in_width;
          weight_width_nxt = cfg_weight_width;
        end
      end
      ST_CLR: begin
        state_nxt = (len_q != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (req_fire_c) begin
          issued_nxt = issued_sum_c;
          if (issued_sum_c >= {1'b0, len_q}) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Only the product landing this cycle may remain in flight.
        if ((dly_q & ~ACC_BIT) == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_fire_c) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    cfg_ready_d    = (state_nxt == ST_IDLE);
    busy_d         = (state_nxt != ST_IDLE);
    acc_clr_d      = (state_nxt == ST_CLR);
    out_valid_d    = (state_nxt == ST_DONE);
    op_req_valid_d = (state_nxt == ST_RUN);
    if (state_nxt == ST_RUN) begin
      remaining_c    = {1'b0, len_nxt} - issued_nxt;
      op_req_idx_d   = issued_nxt[LEN_W-1:0];
      op_req_lanes_d = (remaining_c < CNT_W'(lanes_nxt)) ? 5'(remaining_c) : lanes_nxt;
    end
  end

  // State, job context and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      lanes_q        <= '0;
      issued_q       <= '0;
      dly_q          <= '0;
      in_width_q     <= '0;
      weight_width_q <= '0;
      cfg_ready      <= 1'b1;
      cfg_err        <= 1'b0;
      op_req_valid   <= 1'b0;
      op_req_idx     <= '0;
      op_req_lanes   <= '0;
      acc_clr        <= 1'b0;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      len_q          <= len_nxt;
      lanes_q        <= lanes_nxt;
      issued_q       <= issued_nxt;
      dly_q          <= dly_nxt;
      in_width_q     <= in_width_nxt;
      weight_width_q <= weight_width_nxt;
      cfg_ready      <= cfg_ready_d;
      cfg_err        <= cfg_err_d;
      op_req_valid   <= op_req_valid_d;
      op_req_idx     <= op_req_idx_d;
      op_req_lanes   <= op_req_lanes_d;
      acc_clr        <= acc_clr_d;
      out_valid      <= out_valid_d;
      busy           <= busy_d;
    end
  end

  // Product arrival at the accumulator: request fire delayed PIPE_DEPTH cycles.
  assign acc_en = dly_q[PIPE_DEPTH-1];

`ifdef FUSION_CTRL_PERF_EN
  // Active-cycle counter for CLR/RUN/DRAIN, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles <= '0;
    end else if (cfg_accept_c) begin
      perf_cycles <= '0;
    end else if (((state_q == ST_CLR) || (state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                 (perf_cycles != 32'hFFFF_FFFF)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule
